// File: rtl/borrow_pipe_pkg.sv
// Shared arithmetic types and defaults for the pipelined borrow-lookahead subtractor.
package borrow_pipe_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned GROUP_DEF = 4;

  typedef logic [WIDTH_DEF-1:0] word_t;

  typedef struct packed {
    logic bout;
    logic zero;
    logic ovf;
  } flag_t;

endpackage

// File: rtl/borrow_la_group.sv
// GROUP-bit borrow-lookahead cell: group generate/propagate plus in-group borrows.
module borrow_la_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] i_a,
  input  logic [GROUP-1:0] i_b,
  input  logic             i_bin,
  output logic             o_gg,
  output logic             o_gp,
  output logic [GROUP-1:0] o_borrow
);

  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_p;

  // Bit generate (a=0,b=1) and propagate (a==b) terms.
  assign w_g = ~i_a & i_b;
  assign w_p = ~(i_a ^ i_b);

  // In-group borrows as flat sum-of-products from the group borrow-in; bit 0 is the borrow-in itself.
  always_comb begin : p_bits
    logic v_acc;
    logic v_term;
    v_acc    = 1'b0;
    v_term   = 1'b0;
    o_borrow = '0;
    for (int unsigned k = 0; k < GROUP; k++) begin
      v_acc = i_bin;
      for (int unsigned m = 0; m < k; m++) begin
        v_acc = v_acc & w_p[m];
      end
      for (int unsigned j = 0; j < k; j++) begin
        v_term = w_g[j];
        for (int unsigned m = j + 1; m < k; m++) begin
          v_term = v_term & w_p[m];
        end
        v_acc = v_acc | v_term;
      end
      o_borrow[k] = v_acc;
    end
  end

  // Group-level generate and propagate for the second lookahead level.
  always_comb begin : p_group
    logic v_term;
    v_term = 1'b0;
    o_gp   = &w_p;
    o_gg   = 1'b0;
    for (int unsigned j = 0; j < GROUP; j++) begin
      v_term = w_g[j];
      for (int unsigned m = j + 1; m < GROUP; m++) begin
        v_term = v_term & w_p[m];
      end
      o_gg = o_gg | v_term;
    end
  end

endmodule

// File: rtl/borrow_pipe.sv
// Two-stage pipelined borrow-lookahead subtractor, d = a - b - bin, with valid/ready on both sides.
module borrow_pipe
  import borrow_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned GROUP = GROUP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned NG = WIDTH / GROUP;

  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic [NG:0]      w_gcin;
  logic [WIDTH:0]   w_borrow;
  logic             w_adv1;
  logic             w_adv2;
  logic [WIDTH-1:0] w_d;
  flag_t            w_flags;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_borrow;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_d;
  flag_t            r_flags;

  // First lookahead level: one cell per group, fed by its resolved group borrow-in.
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    borrow_la_group #(.GROUP(GROUP)) u_grp (
      .i_a      (a[gi*GROUP +: GROUP]),
      .i_b      (b[gi*GROUP +: GROUP]),
      .i_bin    (w_gcin[gi]),
      .o_gg     (w_gg[gi]),
      .o_gp     (w_gp[gi]),
      .o_borrow (w_borrow[gi*GROUP +: GROUP])
    );
  end

  // Second lookahead level: each group borrow-in as a flat sum-of-products of group G/P and bin.
  always_comb begin : p_groups
    logic v_acc;
    logic v_term;
    v_acc  = 1'b0;
    v_term = 1'b0;
    w_gcin = '0;
    for (int unsigned k = 0; k <= NG; k++) begin
      v_acc = bin;
      for (int unsigned m = 0; m < k; m++) begin
        v_acc = v_acc & w_gp[m];
      end
      for (int unsigned j = 0; j < k; j++) begin
        v_term = w_gg[j];
        for (int unsigned m = j + 1; m < k; m++) begin
          v_term = v_term & w_gp[m];
        end
        v_acc = v_acc | v_term;
      end
      w_gcin[k] = v_acc;
    end
  end

  assign w_borrow[WIDTH] = w_gcin[NG];

  // Handshake: a stage advances when it is empty or the stage after it advances.
  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign in_ready = w_adv1;

  // Stage 1: operands and full borrow vector; borrow bit 0 carries bin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_borrow   <= '0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      r_a        <= a;
      r_b        <= b;
      r_borrow   <= w_borrow;
    end
  end

  // Stage 2 combinational: difference bits and status flags from stage-1 registers.
  always_comb begin
    w_d          = r_a ^ r_b ^ r_borrow[WIDTH-1:0];
    w_flags      = '0;
    w_flags.bout = r_borrow[WIDTH];
    w_flags.zero = (w_d == '0);
    w_flags.ovf  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_d[WIDTH-1] != r_a[WIDTH-1]);
  end

  // Stage 2 register: holds result and flags while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_d         <= '0;
      r_flags     <= '0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      r_d         <= w_d;
      r_flags     <= w_flags;
    end
  end

  assign out_valid = r_out_valid;
  assign d         = r_d;
  assign bout      = r_flags.bout;
  assign zero      = r_flags.zero;
  assign ovf       = r_flags.ovf;

endmodule

// File: tb/tb_borrow_pipe.sv
// Self-checking bench for borrow_pipe: directed vectors, backpressure, reset flush, random scoreboard.
module tb_borrow_pipe;
  import borrow_pipe_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  word_t a;
  word_t b;
  logic  bin;
  logic  in_valid;
  logic  in_ready;
  word_t d;
  logic  bout;
  logic  zero;
  logic  ovf;
  logic  out_valid;
  logic  out_ready;

  int n_chk = 0;
  int n_err = 0;

  logic [34:0] sb_q[$];

  always #5 clk = ~clk;

  borrow_pipe #(.WIDTH(32), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {bout, zero, ovf, d} from a 33-bit subtraction.
  function automatic logic [34:0] model(input word_t ma, input word_t mb, input logic mbin);
    logic [32:0] w;
    logic        o;
    w = {1'b0, ma} - {1'b0, mb} - 33'(mbin);
    o = (ma[31] != mb[31]) && (w[31] != ma[31]);
    return {w[32], (w[31:0] == 32'd0), o, w[31:0]};
  endfunction

  // Scoreboard and stall-stability monitor, sampling on the falling edge.
  initial begin : monitor
    logic        prev_stall;
    logic [34:0] prev_out;
    logic [34:0] exp_v;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", 64'(out_valid), 64'd1);
          check_eq("hold_data", 64'({bout, zero, ovf, d}), 64'(prev_out));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check_eq("spurious_out", 64'(out_valid), 64'd0);
          end else begin
            exp_v = sb_q.pop_front();
            check_eq("sb_result", 64'({bout, zero, ovf, d}), 64'(exp_v));
          end
        end
        if (in_valid && in_ready) sb_q.push_back(model(a, b, bin));
        prev_stall = out_valid && !out_ready;
        prev_out   = {bout, zero, ovf, d};
      end
    end
  end

  // One isolated operation with out_ready high; checks latency and hand-computed results.
  task automatic run_op(input string tag, input word_t ta, input word_t tb_v, input logic tbin,
                        input word_t ed, input logic eb, input logic ez, input logic eo);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_d"}, 64'(d), 64'(ed));
    check_eq({tag, "_flags"}, 64'({bout, zero, ovf}), 64'({eb, ez, eo}));
  endtask

  initial begin : stim
    a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    #2;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_d", 64'(d), 64'd0);
    check_eq("rst_flags", 64'({bout, zero, ovf}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed vectors.
    run_op("basic", 32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
    run_op("under", 32'd3, 32'd5, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    run_op("zero", 32'd7, 32'd6, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    run_op("ovf_neg", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    run_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    run_op("eq_bin", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("all0", 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Backpressure: two entries fill the pipe, third is refused until release.
    out_ready = 1'b0;
    a = 32'd100; b = 32'd1; bin = 1'b0; in_valid = 1'b1;
    check_eq("bp_rdy0", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    a = 32'd0; b = 32'd1; bin = 1'b0;
    check_eq("bp_rdy1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    a = 32'd10; b = 32'd20; bin = 1'b1;
    check_eq("bp_full", 64'(in_ready), 64'd0);
    check_eq("bp_first_valid", 64'(out_valid), 64'd1);
    check_eq("bp_first_d", 64'(d), 64'd99);
    @(posedge clk); #1;
    check_eq("bp_still_full", 64'(in_ready), 64'd0);
    check_eq("bp_stable_d", 64'(d), 64'd99);
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check_eq("bp_second_d", 64'(d), 64'hFFFF_FFFF);
    a = 32'h4000_0000; b = 32'hC000_0000; bin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_third_d", 64'(d), 64'hFFFF_FFF5);
    @(posedge clk); #1;
    check_eq("bp_fourth_d", 64'(d), 64'h8000_0000);
    check_eq("bp_fourth_flags", 64'({bout, zero, ovf}), 64'({1'b1, 1'b0, 1'b1}));
    @(posedge clk); #1;
    check_eq("bp_empty", 64'(out_valid), 64'd0);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    a = 32'd50; b = 32'd8; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'd9; b = 32'd4; bin = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("mid_inflight", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_ready", 64'(in_ready), 64'd1);
    check_eq("mid_rst_d", 64'(d), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("mid_no_stale", 64'(out_valid), 64'd0);
    end

    // Random regression against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      bin       = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    check_eq("final_idle", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
